// File: rtl/layer2_sched_if.sv
// Bundle of the layer-2 scheduler handshake, bias ROM, result-memory write and pooling signals.
interface layer2_sched_if;
  logic              start;
  logic              res_valid;
  logic signed [7:0] res_value;
  logic              res_ready;
  logic        [3:0] bias_rd_addr;
  logic signed [7:0] bias_rd_data;
  logic              store;
  logic        [7:0] w_addr;
  logic        [3:0] out_c;
  logic signed [7:0] bias;
  logic signed [7:0] value;
  logic              cout_done;
  logic              pool;
  logic              pool_done;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, res_valid, res_value, bias_rd_data, pool_done,
    input  res_ready, bias_rd_addr, store, w_addr, out_c, bias, value,
           cout_done, pool, busy, done, err
  );

  modport slave (
    input  start, res_valid, res_value, bias_rd_data, pool_done,
    output res_ready, bias_rd_addr, store, w_addr, out_c, bias, value,
           cout_done, pool, busy, done, err
  );
endinterface

// File: rtl/layer2_sched.sv
// Layer-2 write scheduler: streams N_PIX x N_CH conv results into the result memory,
// then runs a watchdog-guarded pooling handshake before signalling pass completion.
module layer2_sched #(
  parameter int unsigned N_PIX        = 196,
  parameter int unsigned N_CH         = 16,
  parameter int unsigned POOL_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  layer2_sched_if.slave  l2_if
);

  localparam int unsigned PIX_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned WD_W     = (POOL_TIMEOUT > 1) ? $clog2(POOL_TIMEOUT) : 1;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned CH_SEL_W = 4;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_STORE, S_FLUSH, S_POOL, S_RELEASE, S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [PIX_W-1:0]          pix_q, pix_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      store_q, store_d;
  logic [ADDR_W-1:0]         w_addr_q, w_addr_d;
  logic [CH_SEL_W-1:0]       out_c_q, out_c_d;
  logic signed [DATA_W-1:0]  value_q, value_d;
  logic signed [DATA_W-1:0]  bias_q, bias_d;
  logic                      cout_done_q, cout_done_d;
  logic                      pool_q, pool_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      xfer_c;

  assign xfer_c = l2_if.res_valid && (state_q == S_STORE);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    ch_d        = ch_q;
    wd_d        = '0;
    store_d     = 1'b0;
    w_addr_d    = w_addr_q;
    out_c_d     = out_c_q;
    value_d     = value_q;
    bias_d      = bias_q;
    cout_done_d = 1'b0;
    pool_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (l2_if.start) begin
          state_d = S_STORE;
          pix_d   = '0;
          ch_d    = '0;
          err_d   = 1'b0;
        end
      end
      S_STORE: begin
        if (xfer_c) begin
          store_d  = 1'b1;
          w_addr_d = ADDR_W'(pix_q);
          out_c_d  = CH_SEL_W'(ch_q);
          value_d  = l2_if.res_value;
          bias_d   = l2_if.bias_rd_data;
          if (pix_q == PIX_W'(N_PIX - 1)) begin
            pix_d = '0;
            if (ch_q == CH_W'(N_CH - 1)) begin
              ch_d    = '0;
              state_d = S_FLUSH;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
      end
      S_FLUSH: begin
        cout_done_d = 1'b1;
        state_d     = S_POOL;
      end
      S_POOL: begin
        // pool stays high only while the next cycle is still POOL, so it drops with the exit
        wd_d = wd_q + WD_W'(1);
        if (l2_if.pool_done) begin
          state_d = S_RELEASE;
        end else if (wd_q == WD_W'(POOL_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          pool_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!l2_if.pool_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      ch_q        <= '0;
      wd_q        <= '0;
      store_q     <= 1'b0;
      w_addr_q    <= '0;
      out_c_q     <= '0;
      value_q     <= '0;
      bias_q      <= '0;
      cout_done_q <= 1'b0;
      pool_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      ch_q        <= ch_d;
      wd_q        <= wd_d;
      store_q     <= store_d;
      w_addr_q    <= w_addr_d;
      out_c_q     <= out_c_d;
      value_q     <= value_d;
      bias_q      <= bias_d;
      cout_done_q <= cout_done_d;
      pool_q      <= pool_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign l2_if.res_ready    = (state_q == S_STORE);
  assign l2_if.bias_rd_addr = CH_SEL_W'(ch_q);
  assign l2_if.store        = store_q;
  assign l2_if.w_addr       = w_addr_q;
  assign l2_if.out_c        = out_c_q;
  assign l2_if.value        = value_q;
  assign l2_if.bias         = bias_q;
  assign l2_if.cout_done    = cout_done_q;
  assign l2_if.pool         = pool_q;
  assign l2_if.busy         = busy_q;
  assign l2_if.done         = done_q;
  assign l2_if.err          = err_q;

endmodule

// File: tb/tb_layer2_sched.sv
// Directed testbench for layer2_sched: scoreboarded store stream, pooling handshake,
// watchdog timeout, start filtering and asynchronous reset.
module tb_layer2_sched;

  localparam int N_PIX = 196;
  localparam int N_CH  = 16;
  localparam int TOTAL = N_PIX * N_CH;

  typedef struct packed {
    logic [7:0] w;
    logic [3:0] c;
    logic [7:0] v;
    logic [7:0] b;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  layer2_sched_if bus ();

  layer2_sched #(.N_PIX(N_PIX), .N_CH(N_CH), .POOL_TIMEOUT(1024)) dut (
    .clk   (clk),
    .rst   (rst),
    .l2_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bias_of(input logic [3:0] a);
    return 8'(8'(a) * 8'd29 + 8'd7);
  endfunction

  // Bias ROM model
  always_comb bus.bias_rd_data = bias_of(bus.bias_rd_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_store"},     32'(bus.store),     32'd0);
    chk({pfx, "_cout_done"}, 32'(bus.cout_done), 32'd0);
    chk({pfx, "_pool"},      32'(bus.pool),      32'd0);
    chk({pfx, "_busy"},      32'(bus.busy),      32'd0);
    chk({pfx, "_done"},      32'(bus.done),      32'd0);
    chk({pfx, "_err"},       32'(bus.err),       32'd0);
    chk({pfx, "_res_ready"}, 32'(bus.res_ready), 32'd0);
    chk({pfx, "_w_addr"},    32'(bus.w_addr),    32'd0);
    chk({pfx, "_out_c"},     32'(bus.out_c),     32'd0);
    chk({pfx, "_value"},     32'($unsigned(bus.value)), 32'd0);
    chk({pfx, "_bias"},      32'($unsigned(bus.bias)),  32'd0);
    chk({pfx, "_bias_addr"}, 32'(bus.bias_rd_addr), 32'd0);
  endtask

  // Start a pass from IDLE and feed stop_after results (valid every period cycles)
  task automatic run_stream(input int period, input bit hold, input bit noise, input int stop_after);
    int   pix = 0;
    int   ch = 0;
    int   sent = 0;
    int   cyc = 0;
    int   nstore = 0;
    bit   xfer;
    exp_t e;
    bus.start     = 1'b1;
    bus.pool_done = 1'b0;
    bus.res_valid = 1'b0;
    tick();
    chk("start_busy",  32'(bus.busy),      32'd1);
    chk("start_ready", 32'(bus.res_ready), 32'd1);
    chk("start_err",   32'(bus.err),       32'd0);
    if (!hold) bus.start = 1'b0;
    while (sent < stop_after && cyc < stop_after * period + 100) begin
      bus.res_valid = (cyc % period == 0);
      bus.res_value = 8'($urandom);
      bus.pool_done = noise && (stop_after - sent > 4) && (cyc % 2 == 1);
      chk("ready",     32'(bus.res_ready),    32'd1);
      chk("bias_addr", 32'(bus.bias_rd_addr), 32'(ch));
      xfer = bus.res_valid;
      if (xfer) begin
        q.push_back({8'(pix), 4'(ch), 8'($unsigned(bus.res_value)), bias_of(4'(ch))});
        sent++;
        if (pix == N_PIX - 1) begin
          pix = 0;
          ch++;
        end else begin
          pix++;
        end
      end
      tick();
      chk("store", 32'(bus.store), 32'(xfer));
      if (bus.store) nstore++;
      if (xfer) begin
        e = q.pop_front();
        chk("w_addr", 32'(bus.w_addr), 32'(e.w));
        chk("out_c",  32'(bus.out_c),  32'(e.c));
        chk("value",  32'($unsigned(bus.value)), 32'(e.v));
        chk("bias",   32'($unsigned(bus.bias)),  32'(e.b));
        if (nstore == 1) begin
          chk("first_w_addr", 32'(bus.w_addr), 32'd0);
          chk("first_out_c",  32'(bus.out_c),  32'd0);
        end
        if (nstore == TOTAL) begin
          chk("last_w_addr", 32'(bus.w_addr), 32'd195);
          chk("last_out_c",  32'(bus.out_c),  32'd15);
        end
      end
      cyc++;
    end
    chk("stream_budget", 32'(sent), 32'(stop_after));
    chk("store_count",   32'(nstore), 32'(stop_after));
    if (stop_after == TOTAL) begin
      chk("flush_ready", 32'(bus.res_ready), 32'd0);
      chk("flush_cout",  32'(bus.cout_done), 32'd0);
      tick();
      chk("post_store",  32'(bus.store),     32'd0);
      chk("cout_done",   32'(bus.cout_done), 32'd1);
      chk("pool_early",  32'(bus.pool),      32'd0);
      chk("busy_pool",   32'(bus.busy),      32'd1);
      tick();
      chk("cout_pulse",  32'(bus.cout_done), 32'd0);
      chk("pool_rise",   32'(bus.pool),      32'd1);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_value = 8'd0;
    bus.pool_done = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // pool_done in IDLE must have no effect
    bus.pool_done = 1'b1;
    repeat (3) tick();
    chk("idle_pool_done_busy", 32'(bus.busy), 32'd0);
    chk("idle_pool_done_pool", 32'(bus.pool), 32'd0);
    bus.pool_done = 1'b0;

    // Pass A: res_valid held high, pool_done after 50 cycles, start pulses during POOL
    run_stream(1, 1'b0, 1'b0, TOTAL);
    for (int i = 0; i < 50; i++) begin
      bus.start = (i % 2 == 0);
      tick();
      chk("pool_hold", 32'(bus.pool), 32'd1);
    end
    bus.start     = 1'b0;
    bus.pool_done = 1'b1;
    tick();
    chk("pool_fall", 32'(bus.pool), 32'd0);
    chk("a_err",     32'(bus.err),  32'd0);
    tick();
    chk("release_pool", 32'(bus.pool), 32'd0);
    chk("release_done", 32'(bus.done), 32'd0);
    chk("release_busy", 32'(bus.busy), 32'd1);
    bus.pool_done = 1'b0;
    tick();
    chk("a_done", 32'(bus.done), 32'd1);
    tick();
    chk("a_done_pulse", 32'(bus.done), 32'd0);
    chk("a_idle",       32'(bus.busy), 32'd0);
    chk("a_err_end",    32'(bus.err),  32'd0);

    // Pass B: throttled input, start held throughout, pool_done noise, watchdog timeout
    run_stream(3, 1'b1, 1'b1, TOTAL);
    bus.pool_done = 1'b0;
    repeat (1022) tick();
    chk("wd_pool_before", 32'(bus.pool), 32'd1);
    chk("wd_err_before",  32'(bus.err),  32'd0);
    tick();
    chk("wd_err",  32'(bus.err),  32'd1);
    chk("wd_pool", 32'(bus.pool), 32'd0);
    chk("wd_done_early", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    tick();
    chk("b_done", 32'(bus.done), 32'd1);
    tick();
    chk("b_done_pulse", 32'(bus.done), 32'd0);
    chk("b_idle",       32'(bus.busy), 32'd0);
    chk("b_err_sticky", 32'(bus.err),  32'd1);
    tick();
    chk("b_no_restart", 32'(bus.busy), 32'd0);

    // Pass C: err cleared by start, then abort at pixel 100 of channel 5
    run_stream(1, 1'b0, 1'b0, 5 * N_PIX + 100);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    tick();
    rst = 1'b0;
    q.delete();
    tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    run_stream(1, 1'b0, 1'b0, 3);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer2_sched.md
LAYER2_SCHED -- requirements
Module: layer2_sched

Interface
REQ-001 Parameter N_PIX, 196, pixels per output channel (14x14 conv result).
REQ-002 Parameter N_CH, 16, output channels per layer pass.
REQ-003 Parameter POOL_TIMEOUT, 1024, max cycles POOL may wait for pool_done.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin one layer pass; sampled only in IDLE.
REQ-007 res_valid  in  1  conv result available.
REQ-008 res_value  in  8  signed conv result.
REQ-009 res_ready  out  1  scheduler accepts result; high only in STORE.
REQ-010 bias_rd_addr  out  4  bias ROM address, equals current channel counter.
REQ-011 bias_rd_data  in  8  signed bias, combinational ROM read of bias_rd_addr.
REQ-012 store  out  1  write strobe to layer-2 result memory.
REQ-013 w_addr  out  8  write pixel address.
REQ-014 out_c  out  4  write channel select.
REQ-015 bias  out  8  signed bias accompanying store.
REQ-016 value  out  8  signed value accompanying store.
REQ-017 cout_done  out  1  all channels written pulse.
REQ-018 pool  out  1  pooling enable level.
REQ-019 pool_done  in  1  pooling complete, from result memory.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pass-complete pulse.
REQ-022 err  out  1  sticky pool-timeout flag; cleared by rst or next accepted start.

Function
REQ-023 FSM states IDLE, STORE, FLUSH, POOL, RELEASE, DONE; one-hot or binary at implementer's choice.
REQ-024 IDLE: start=1 -> STORE, pixel counter=0, channel counter=0, err cleared; start ignored in all other states.
REQ-025 Transfer occurs when res_valid && res_ready; res_ready is combinational (state==STORE).
REQ-026 On transfer, next cycle: store=1 for exactly one cycle, w_addr=pixel counter, out_c=channel counter, value=res_value, bias=bias_rd_data, all registered from the transfer cycle.
REQ-027 Pixel counter increments per transfer; at N_PIX-1 wraps to 0 and channel counter increments.
REQ-028 Transfer with pixel=N_PIX-1 and channel=N_CH-1 -> FLUSH; res_ready drops the following cycle (no extra transfer accepted).
REQ-029 No transfer in a cycle -> store=0; w_addr/out_c/value/bias hold last values.
REQ-030 FLUSH: cout_done=1 for one cycle (cycle after final store pulse), then -> POOL.
REQ-031 POOL: pool=1; watchdog counts from 0; pool_done=1 -> RELEASE; watchdog reaching POOL_TIMEOUT-1 without pool_done -> err=1, -> RELEASE.
REQ-032 RELEASE: pool=0; waits for pool_done=0, then -> DONE; pool_done already 0 -> DONE next cycle.
REQ-033 DONE: done=1 for one cycle, -> IDLE.
REQ-034 pool_done asserted outside POOL/RELEASE is ignored.
REQ-035 Counters wide enough for N_PIX-1 and N_CH-1; no overflow beyond wrap rule.

Reset
REQ-036 rst=1 forces IDLE immediately, any state including mid-STORE or POOL.
REQ-037 Reset values: store, cout_done, pool, busy, done, err, res_ready = 0; w_addr, out_c, value, bias, counters, watchdog = 0.
REQ-038 Partial pass aborted by reset is not resumed; next start restarts at pixel 0, channel 0.

Verification
REQ-039 Full pass, res_valid held high: start -> 3136 store pulses, first w_addr=0/out_c=0, last w_addr=195/out_c=15, cout_done one cycle after last store, pool rises next cycle.
REQ-040 Throttled input (res_valid every 3rd cycle): store count and address sequence identical to REQ-039; no store while res_valid=0.
REQ-041 pool_done raised 50 cycles into POOL, held 2 cycles: pool falls next cycle, done pulses once after pool_done low, err=0, back to IDLE.
REQ-042 pool_done never raised: err=1 after POOL_TIMEOUT cycles, pool=0, done pulses; err cleared by next start.
REQ-043 rst pulse at pixel 100 of channel 5: all outputs zero asynchronously; new start gives first store at w_addr=0, out_c=0.
REQ-044 start held high through entire pass and start pulses during POOL: exactly one pass executed per IDLE entry, no counter disturbance.
